// File: rtl/star_scanner_if.sv
// Bundle of the scanner's control, pixel-memory, exclusion-list and hit
// signals. The slave view belongs to star_scanner; the master view belongs
// to whatever drives it (FSM, memory, box writer).
interface star_scanner_if #(
    parameter int xSz   = 8,
    parameter int ySz   = 7,
    parameter int colSz = 3
);
    logic             start;
    logic             ack;
    logic [14:0]      mem_addr;
    logic [colSz-1:0] mem_data;
    logic             box_wr;
    logic [xSz-1:0]   box_left;
    logic [xSz-1:0]   box_right;
    logic [ySz-1:0]   box_top;
    logic [ySz-1:0]   box_bottom;
    logic             clear_boxes;
    logic [xSz-1:0]   xCount;
    logic [ySz-1:0]   yCount;
    logic             starFound;
    logic             scanDone;
    logic             busy;
    logic [3:0]       boxCount;
    logic             boxOverflow;

    modport slave (
        input  start, ack, mem_data, box_wr, box_left, box_right,
               box_top, box_bottom, clear_boxes,
        output mem_addr, xCount, yCount, starFound, scanDone, busy,
               boxCount, boxOverflow
    );

    modport master (
        output start, ack, mem_data, box_wr, box_left, box_right,
               box_top, box_bottom, clear_boxes,
        input  mem_addr, xCount, yCount, starFound, scanDone, busy,
               boxCount, boxOverflow
    );
endinterface

// File: rtl/star_scanner.sv
// Raster-order star search. Issues one pixel address per cycle, checks the
// returned colour one cycle later against the background and the list of
// already-drawn boxes, and parks on the first new star until acknowledged.
module star_scanner #(
    parameter int               xSz       = 8,
    parameter int               ySz       = 7,
    parameter int               colSz     = 3,
    parameter int               X_MAX     = 160,
    parameter int               Y_MAX     = 120,
    parameter logic [colSz-1:0] BG_COL    = 3'b000,
    parameter int               MAX_BOXES = 8
) (
    input  logic clk,
    input  logic reset,
    star_scanner_if.slave bus
);
    localparam int              ADDR_SZ  = 15;
    localparam logic [xSz-1:0]  X_LAST   = xSz'(X_MAX - 1);
    localparam logic [ySz-1:0]  Y_LAST   = ySz'(Y_MAX - 1);
    localparam logic [3:0]      BOX_FULL = 4'(MAX_BOXES);

    typedef enum logic [1:0] {IDLE, SCAN, FOUND, DONE} stateT;

    typedef struct packed {
        logic [xSz-1:0] left;
        logic [xSz-1:0] right;
        logic [ySz-1:0] top;
        logic [ySz-1:0] bottom;
    } boxT;

    stateT state, nextState;

    // Issue stage: next pixel to request from memory.
    logic [xSz-1:0]     addrX;
    logic [ySz-1:0]     addrY;
    logic [ADDR_SZ-1:0] memAddr;
    logic               issueDone;

    // Check stage: pixel whose colour is on mem_data this cycle.
    logic               chkValid;
    logic [xSz-1:0]     chkX;
    logic [ySz-1:0]     chkY;
    logic [ADDR_SZ-1:0] chkAddr;

    // Held hit.
    logic [xSz-1:0]     hitX;
    logic [ySz-1:0]     hitY;
    logic [ADDR_SZ-1:0] hitAddr;
    logic               starFound;
    logic               scanDone;

    // Exclusion list.
    boxT                boxes [MAX_BOXES];
    logic [3:0]         boxCount;
    logic               boxOverflow;
    logic               boxWrEn;
    boxT                newBox;

    logic startReq, issueEn, inBox, chkHit, chkLast, hitLast, ackTaken;

    assign startReq = bus.start && (state == IDLE || state == DONE);
    assign issueEn  = (state == SCAN) && !issueDone;
    assign chkHit   = (state == SCAN) && chkValid && (bus.mem_data != BG_COL) && !inBox;
    assign chkLast  = (state == SCAN) && chkValid && (chkX == X_LAST) && (chkY == Y_LAST);
    assign hitLast  = (hitX == X_LAST) && (hitY == Y_LAST);
    assign ackTaken = (state == FOUND) && bus.ack;
    assign boxWrEn  = bus.box_wr && !bus.clear_boxes && (boxCount < BOX_FULL);
    assign newBox   = '{left: bus.box_left, right: bus.box_right,
                        top: bus.box_top, bottom: bus.box_bottom};

    // Is the pixel in the check stage covered by any valid box?
    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        inBox = 1'b0;
        for (int i = 0; i < MAX_BOXES; i++) begin
            if (4'(i) < boxCount &&
                boxes[i].left <= chkX && chkX <= boxes[i].right &&
                boxes[i].top  <= chkY && chkY <= boxes[i].bottom)
                inBox = 1'b1;
        end
    end

    // Next-state selection for the scan controller.
    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: if (bus.start) nextState = SCAN;
            SCAN: begin
                if (chkHit)       nextState = FOUND;
                else if (chkLast) nextState = DONE;
            end
            FOUND:      if (bus.ack) nextState = hitLast ? DONE : SCAN;
            default:    nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Address generation, check pipeline and hit capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            addrX     <= '0;
            addrY     <= '0;
            memAddr   <= '0;
            issueDone <= 1'b0;
            chkValid  <= 1'b0;
            chkX      <= '0;
            chkY      <= '0;
            chkAddr   <= '0;
            hitX      <= '0;
            hitY      <= '0;
            hitAddr   <= '0;
            starFound <= 1'b0;
            scanDone  <= 1'b0;
        end else begin
            // A hit discards the read issued alongside it.
            chkValid <= issueEn && !chkHit;
            if (issueEn) begin
                chkX    <= addrX;
                chkY    <= addrY;
                chkAddr <= memAddr;
            end

            if (startReq) begin
                addrX     <= '0;
                addrY     <= '0;
                memAddr   <= '0;
                issueDone <= 1'b0;
                scanDone  <= 1'b0;
            end else if (ackTaken) begin
                starFound <= 1'b0;
                if (hitLast) begin
                    scanDone <= 1'b1;
                end else begin
                    if (hitX == X_LAST) begin
                        addrX <= '0;
                        addrY <= hitY + 1'b1;
                    end else begin
                        addrX <= hitX + 1'b1;
                        addrY <= hitY;
                    end
                    memAddr   <= hitAddr + 1'b1;
                    issueDone <= 1'b0;
                end
            end else if (issueEn) begin
                if (addrX == X_LAST) begin
                    if (addrY == Y_LAST) begin
                        issueDone <= 1'b1;
                    end else begin
                        addrX   <= '0;
                        addrY   <= addrY + 1'b1;
                        memAddr <= memAddr + 1'b1;
                    end
                end else begin
                    addrX   <= addrX + 1'b1;
                    memAddr <= memAddr + 1'b1;
                end
            end

            if (chkHit) begin
                hitX      <= chkX;
                hitY      <= chkY;
                hitAddr   <= chkAddr;
                starFound <= 1'b1;
            end else if (chkLast) begin
                scanDone  <= 1'b1;
            end
        end
    end

    // Exclusion-list occupancy and overflow flag; clear beats a write.
    always_ff @(posedge clk) begin
        if (reset || bus.clear_boxes) begin
            boxCount    <= '0;
            boxOverflow <= 1'b0;
        end else if (bus.box_wr) begin
            if (boxCount < BOX_FULL) boxCount    <= boxCount + 1'b1;
            else                     boxOverflow <= 1'b1;
        end
    end

    // Exclusion-list entry storage.
    always_ff @(posedge clk) begin
        // NOTE: the box entries carry no reset; boxCount alone decides which are valid.
        for (int i = 0; i < MAX_BOXES; i++) begin
            if (!reset && boxWrEn && boxCount == 4'(i)) boxes[i] <= newBox;
        end
    end

    assign bus.mem_addr    = memAddr;
    assign bus.xCount      = hitX;
    assign bus.yCount      = hitY;
    assign bus.starFound   = starFound;
    assign bus.scanDone    = scanDone;
    assign bus.busy        = (state == SCAN) || (state == FOUND);
    assign bus.boxCount    = boxCount;
    assign bus.boxOverflow = boxOverflow;
endmodule

// File: tb/tb_star_scanner.sv
// Self-checking bench for star_scanner: a synchronous-read image model, a
// queue of expected hits filled when the image is painted, and a scan loop
// that pops and compares each reported star.
module tb_star_scanner;
    localparam int X_MAX = 160;
    localparam int Y_MAX = 120;
    localparam int NPIX  = X_MAX * Y_MAX;

    typedef struct {
        int x;
        int y;
    } hitT;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    star_scanner_if #(.xSz(8), .ySz(7), .colSz(3)) bus();

    star_scanner dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [2:0] img [NPIX];

    // Synchronous-read pixel memory.
    always @(posedge clk) bus.mem_data <= img[bus.mem_addr];

    hitT expQ[$];
    int  nChecks = 0;
    int  nFails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic setPix(input int x, input int y, input logic [2:0] col, input bit expectHit);
        hitT h;
        img[y * X_MAX + x] = col;
        if (expectHit) begin
            h.x = x;
            h.y = y;
            expQ.push_back(h);
        end
    endtask

    task automatic writeBox(input int l, input int r, input int t, input int b);
        @(negedge clk);
        bus.box_left   = 8'(l);
        bus.box_right  = 8'(r);
        bus.box_top    = 7'(t);
        bus.box_bottom = 7'(b);
        bus.box_wr     = 1'b1;
        @(negedge clk);
        bus.box_wr     = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " xCount"},      32'(bus.xCount),      0);
        check({tag, " yCount"},      32'(bus.yCount),      0);
        check({tag, " mem_addr"},    32'(bus.mem_addr),    0);
        check({tag, " starFound"},   32'(bus.starFound),   0);
        check({tag, " scanDone"},    32'(bus.scanDone),    0);
        check({tag, " busy"},        32'(bus.busy),        0);
        check({tag, " boxCount"},    32'(bus.boxCount),    0);
        check({tag, " boxOverflow"}, 32'(bus.boxOverflow), 0);
    endtask

    // Pulse start, then service every hit until the scan ends; cycle 1 is
    // the first cycle after start was sampled.
    task automatic runScan(input int firstHitCycle, input bit pokeStart);
        int  cyc  = 0;
        int  hits = 0;
        bit  done = 1'b0;
        hitT e;
        @(negedge clk);
        bus.start = 1'b1;
        while (!done && cyc < 25000) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (bus.starFound) begin
                if (expQ.size() == 0) begin
                    check("unexpected hit", 1, 0);
                    e.x = -1;
                    e.y = -1;
                end else begin
                    e = expQ.pop_front();
                end
                check("hit x", 32'(bus.xCount), e.x);
                check("hit y", 32'(bus.yCount), e.y);
                if (hits == 0) check("first hit cycle", cyc, firstHitCycle);
                repeat (2) begin
                    @(negedge clk);
                    cyc++;
                end
                check("found held", 32'(bus.starFound), 1);
                check("x held", 32'(bus.xCount), e.x);
                bus.ack = 1'b1;
                @(negedge clk);
                cyc++;
                bus.ack = 1'b0;
                check("ack clears found", 32'(bus.starFound), 0);
                if (e.x == X_MAX - 1 && e.y == Y_MAX - 1) begin
                    check("last hit done", 32'(bus.scanDone), 1);
                    check("last hit busy", 32'(bus.busy), 0);
                    done = 1'b1;
                end else begin
                    check("resume addr", 32'(bus.mem_addr), e.y * X_MAX + e.x + 1);
                end
                // A start while scanning must be ignored.
                if (pokeStart && hits == 1) bus.start = 1'b1;
                hits++;
            end else if (bus.scanDone) begin
                done = 1'b1;
            end
        end
        check("scan finished", 32'(done), 1);
        check("all hits seen", expQ.size(), 0);
    endtask

    initial begin
        int  cyc;
        int  maxAddr;
        bit  sawHit;
        hitT e;

        bus.start       = 1'b0;
        bus.ack         = 1'b0;
        bus.box_wr      = 1'b0;
        bus.box_left    = '0;
        bus.box_right   = '0;
        bus.box_top     = '0;
        bus.box_bottom  = '0;
        bus.clear_boxes = 1'b0;
        for (int i = 0; i < NPIX; i++) img[i] = 3'b000;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkAllZero("reset");

        // Blank image: full scan, no hit.
        @(negedge clk);
        bus.start = 1'b1;
        cyc       = 0;
        maxAddr   = 0;
        sawHit    = 1'b0;
        while (!bus.scanDone && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (cyc == 1) begin
                check("blank busy cycle1", 32'(bus.busy), 1);
                check("blank addr cycle1", 32'(bus.mem_addr), 0);
            end
            if (int'(bus.mem_addr) > maxAddr) maxAddr = int'(bus.mem_addr);
            if (bus.starFound) sawHit = 1'b1;
        end
        check("blank done cycle", cyc, 19202);
        check("blank no hit", 32'(sawHit), 0);
        check("blank max addr", maxAddr, NPIX - 1);
        check("blank busy at done", 32'(bus.busy), 0);

        // Populated image with an inclusive box and an inverted box.
        writeBox(10, 11, 10, 10);
        writeBox(50, 20, 0, 119);
        check("two boxes", 32'(bus.boxCount), 2);
        setPix(40,  2,   3'b001, 1'b1);
        setPix(5,   3,   3'b100, 1'b1);
        setPix(159, 4,   3'b010, 1'b1);
        setPix(0,   5,   3'b111, 1'b1);
        setPix(3,   7,   3'b010, 1'b1);
        setPix(10,  10,  3'b101, 1'b0);
        setPix(11,  10,  3'b101, 1'b0);
        setPix(12,  10,  3'b110, 1'b1);
        setPix(30,  50,  3'b011, 1'b1);
        setPix(159, 119, 3'b001, 1'b1);
        runScan(363, 1'b1);

        // Restart from DONE reports the first star again; then reset mid-scan.
        e.x = 40;
        e.y = 2;
        expQ.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        cyc = 0;
        while (!bus.starFound && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
        end
        check("restart hit cycle", cyc, 363);
        e = expQ.pop_front();
        check("restart hit x", 32'(bus.xCount), e.x);
        check("restart hit y", 32'(bus.yCount), e.y);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        repeat (5) @(negedge clk);
        check("mid-scan busy", 32'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        checkAllZero("mid-scan reset");
        reset = 1'b0;

        // Exclusion-list fill, overflow and clear.
        for (int i = 0; i < 8; i++) writeBox(i, i + 1, i, i + 1);
        check("full count", 32'(bus.boxCount), 8);
        check("full no overflow", 32'(bus.boxOverflow), 0);
        writeBox(90, 95, 90, 95);
        check("ninth count", 32'(bus.boxCount), 8);
        check("ninth overflow", 32'(bus.boxOverflow), 1);
        @(negedge clk);
        bus.clear_boxes = 1'b1;
        bus.box_wr      = 1'b1;
        @(negedge clk);
        bus.clear_boxes = 1'b0;
        bus.box_wr      = 1'b0;
        check("clear wins count", 32'(bus.boxCount), 0);
        check("clear overflow", 32'(bus.boxOverflow), 0);
        writeBox(1, 2, 1, 2);
        check("write after clear", 32'(bus.boxCount), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/star_scanner.md
# star_scanner

Raster-order search engine that sits directly upstream of the master FSM and mapTopandBottom. It scans the 160x120 source image held in a synchronous-read pixel memory and stops on the first pixel that is not background and not already inside a drawn box. It then presents that pixel's coordinates as xCount/yCount with a starFound flag, and waits for an acknowledge before resuming. Finished boxes are fed back into an exclusion list so each star is reported exactly once per scan.

## Interface
Parameters:
- xSz, 8, x coordinate width
- ySz, 7, y coordinate width
- colSz, 3, pixel colour width
- X_MAX, 160, image width in pixels
- Y_MAX, 120, image height in pixels
- BG_COL, 3'b000, background colour; any other value is a star pixel
- MAX_BOXES, 8, exclusion list depth

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  synchronous, active-high
- start  in  1  pulse: begin a scan at (0,0)
- ack  in  1  consumer has taken the current hit; resume scanning
- mem_addr  out  15  pixel memory read address, equal to y*X_MAX + x
- mem_data  in  colSz  pixel read data, valid 1 cycle after mem_addr
- box_wr  in  1  append a box to the exclusion list
- box_left, box_right  in  xSz  box x bounds, inclusive
- box_top, box_bottom  in  ySz  box y bounds, inclusive
- clear_boxes  in  1  empty the exclusion list
- xCount  out  xSz  x of the current hit
- yCount  out  ySz  y of the current hit
- starFound  out  1  hit valid; held until ack
- scanDone  out  1  scan reached the end of the image with no pending hit
- busy  out  1  high in SCAN or FOUND
- boxCount  out  4  number of valid exclusion entries
- boxOverflow  out  1  sticky: a box_wr arrived while the list was full

## Operation
- States: IDLE, SCAN, FOUND, DONE.
- Reset (any state): go to IDLE. xCount, yCount, mem_addr, starFound, scanDone, busy, boxCount and boxOverflow all read 0. The exclusion list is emptied.
- IDLE or DONE, start=1: load the address counter to (0,0), clear scanDone, go to SCAN.
- start while in SCAN or FOUND is ignored.
- SCAN pipeline:
  - One pixel is issued per cycle.
  - A check stage holds the coordinates of the pixel issued the previous cycle and tests them against mem_data.
  - Hit condition: mem_data != BG_COL, and the pixel is not inside any valid box (left<=x<=right and top<=y<=bottom).
- Address advance: x increments; at x = X_MAX-1, x wraps to 0 and y increments.
- Address generation stops after (X_MAX-1, Y_MAX-1) has been issued.
- On a hit in the check stage:
  - Register xCount and yCount, set starFound, go to FOUND.
  - The in-flight speculative read is discarded.
- Last pixel checked with no hit: set scanDone, go to DONE.
- FOUND, ack=1:
  - Clear starFound next cycle.
  - If the hit was (X_MAX-1, Y_MAX-1), go to DONE with scanDone=1.
  - Otherwise reload the address counter to the pixel after the hit (raster order) and go to SCAN.
- Exclusion list:
  - box_wr writes entry[boxCount] and increments boxCount.
  - box_wr while boxCount = MAX_BOXES: the write is dropped and boxOverflow is set.
  - clear_boxes sets boxCount=0 and clears boxOverflow.
  - clear_boxes and box_wr in the same cycle: clear wins and the write is dropped.
- Box coordinates are not range-checked. A box with left>right or top>bottom excludes nothing.

## Timing
- start sampled at cycle 0: mem_addr=(0,0) during cycle 1, and mem_data for (0,0) is checked in cycle 2.
- A pixel issued in cycle N is checked in cycle N+1. For a hit, starFound and xCount/yCount are high from cycle N+2.
- Throughput is 1 pixel/cycle. A clean full scan sets scanDone in cycle X_MAX*Y_MAX+2 = 19202 after start.
- ack sampled in cycle M: starFound=0 in M+1, and the next pixel address is issued in M+1.
- A box written in cycle K applies to pixels checked in cycle K+1 or later.
- busy=1 from the cycle after start until scanDone rises.

## Test plan
- Blank image, start: scanDone=1 at cycle 19202; starFound never asserts; mem_addr reaches 19199.
- Single pixel at (5,3), colour 3'b100:
  - starFound=1 with xCount=5, yCount=3, held while ack=0.
  - ack: scan resumes at (6,3), then scanDone.
- Star pixels at (10,10) and (11,10), box_wr (10,11,10,10) before start: no hit; scanDone; boxCount=1.
- Star pixels at (40,2) and (3,7): hits reported in order (40,2) then (3,7), each after ack. A second start restarts at (0,0) and reports (40,2) again.
- Pixel at (159,119) only: hit reported with xCount=159, yCount=119; ack gives DONE directly. Pixel at (159,4) followed by (0,5): x wraps correctly and both are reported.
- Boxes and reset:
  - Nine box_wr with MAX_BOXES=8: boxCount=8, boxOverflow=1.
  - clear_boxes and box_wr together: boxCount=0.
  - reset asserted mid-SCAN: the next cycle shows IDLE with all outputs 0.
